// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART command path: command/response word
// layout, opcode and response-code encodings, and the bus-master state set.
package uart_wb_pkg;

  // Command and response words share the same 2-bit code + 32-bit payload layout.
  localparam int CMD_W  = 34;
  localparam int RSP_W  = 34;
  localparam int DATA_W = 32;

  // Field positions inside a command word.
  localparam int OP_HI  = 33;
  localparam int OP_LO  = 32;
  localparam int PAY_HI = 31;
  localparam int PAY_LO = 0;

  typedef enum logic [1:0] {
    OP_SETADDR = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_SETINC  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    RSP_WRACK  = 2'b00,
    RSP_RDDATA = 2'b01,
    RSP_BUSERR = 2'b10,
    RSP_CFGACK = 2'b11
  } rsp_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RSP  = 2'b11
  } state_t;

  // Pack a response code and its data into a response word.
  function automatic logic [RSP_W-1:0] make_rsp(input rsp_code_t code,
                                                input logic [DATA_W-1:0] data);
    return {code, data};
  endfunction

endpackage

// File: rtl/uart_wb_master.sv
// uart_wb_master: executes decoded UART command words as single-beat
// Wishbone B4 pipelined transactions and returns one response word each.
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int AW      = 30,
  parameter int TIMEOUT = 1023
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stb,
  input  logic [CMD_W-1:0]  i_word,
  output logic              o_busy,
  output logic              o_cmd_drop,
  output logic              o_rsp_stb,
  output logic [RSP_W-1:0]  o_rsp_word,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [DATA_W-1:0] i_wb_data
);

  // Counter wide enough to reach TIMEOUT; one bit minimum when disabled.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_reg, state_next;
  logic [AW-1:0]       addr_reg, addr_next;
  logic                inc_reg, inc_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                we_reg, we_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [RSP_W-1:0]    rsp_word_reg, rsp_word_next;
  logic                drop_reg, drop_next;

  opcode_t             opcode;
  logic [DATA_W-1:0]   payload;
  logic [DATA_W-1:0]   addr_ext;
  logic [AW-1:0]       addr_inc;
  logic                timeout_hit;

  assign opcode   = opcode_t'(i_word[OP_HI:OP_LO]);
  assign payload  = i_word[PAY_HI:PAY_LO];
  assign addr_ext = DATA_W'(addr_reg);
  // Address arithmetic is AW bits wide, so the top address rolls over to zero.
  assign addr_inc = addr_reg + AW'(1);
  // The cycle in which the counter holds TIMEOUT-1 is the last one allowed on the bus.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CW'(TIMEOUT - 1));

  // Bus handshake and status outputs are decoded straight from the state.
  assign o_busy     = (state_reg != ST_IDLE);
  assign o_rsp_stb  = (state_reg == ST_RSP);
  assign o_wb_cyc   = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
  assign o_wb_stb   = (state_reg == ST_REQ);
  assign o_wb_we    = we_reg;
  assign o_wb_addr  = addr_reg;
  assign o_wb_data  = wdata_reg;
  assign o_wb_sel   = 4'hF;
  assign o_cmd_drop = drop_reg;
  assign o_rsp_word = rsp_word_reg;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      inc_reg      <= 1'b0;
      cnt_reg      <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      rsp_word_reg <= '0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      inc_reg      <= inc_next;
      cnt_reg      <= cnt_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
      rsp_word_reg <= rsp_word_next;
      drop_reg     <= drop_next;
    end
  end

  // Next-state logic: command decode, bus handshake, timeout abort and response build.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    inc_next      = inc_reg;
    cnt_next      = cnt_reg;
    we_next       = we_reg;
    wdata_next    = wdata_reg;
    rsp_word_next = rsp_word_reg;
    // Any command arriving outside IDLE (including the RSP cycle) is discarded.
    drop_next     = i_stb && (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        if (i_stb) begin
          case (opcode)
            OP_SETADDR: begin
              addr_next     = payload[AW-1:0];
              rsp_word_next = make_rsp(RSP_CFGACK, {inc_reg, 31'(payload[AW-1:0])});
              state_next    = ST_RSP;
            end
            OP_SETINC: begin
              inc_next      = payload[0];
              rsp_word_next = make_rsp(RSP_CFGACK, {payload[0], 31'(addr_reg)});
              state_next    = ST_RSP;
            end
            OP_WRITE, OP_READ: begin
              we_next    = (opcode == OP_WRITE);
              wdata_next = payload;
              cnt_next   = '0;
              state_next = ST_REQ;
            end
          endcase
        end
      end

      ST_REQ: begin
        // Acks and errors cannot belong to this request yet, so only stall matters.
        cnt_next = cnt_reg + CW'(1);
        if (timeout_hit) begin
          rsp_word_next = make_rsp(RSP_BUSERR, addr_ext);
          we_next       = 1'b0;
          state_next    = ST_RSP;
        end else if (!i_wb_stall) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_next = cnt_reg + CW'(1);
        // Error outranks a simultaneous ack; a real termination outranks the timeout.
        if (i_wb_err) begin
          rsp_word_next = make_rsp(RSP_BUSERR, addr_ext);
          we_next       = 1'b0;
          state_next    = ST_RSP;
        end else if (i_wb_ack) begin
          rsp_word_next = we_reg ? make_rsp(RSP_WRACK, addr_ext)
                                 : make_rsp(RSP_RDDATA, i_wb_data);
          if (inc_reg) begin
            addr_next = addr_inc;
          end
          we_next    = 1'b0;
          state_next = ST_RSP;
        end else if (timeout_hit) begin
          rsp_word_next = make_rsp(RSP_BUSERR, addr_ext);
          we_next       = 1'b0;
          state_next    = ST_RSP;
        end
      end

      ST_RSP: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Consumes the 34-bit command words produced by the UART decoder (one-cycle i_stb plus i_word).
- Executes each command as a Wishbone B4 pipelined single-beat master transaction on a 32-bit bus.
- Returns a 34-bit response word for the UART transmit path.
- Sits between the UART decoder and the system Wishbone interconnect inside the top level.

Parameters:
AW, 30, Wishbone word-address width; the address register is AW bits and wraps modulo 2^AW.
TIMEOUT, 1023, cycles allowed in REQ+WAIT before abort; 0 disables timeout.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_stb  in  1  command valid, one-cycle pulse
i_word  in  34  command: [33:32] opcode, [31:0] payload
o_busy  out  1  high whenever state is not IDLE
o_cmd_drop  out  1  one-cycle pulse; i_stb arrived while busy, command discarded
o_rsp_stb  out  1  one-cycle response valid
o_rsp_word  out  34  response: [33:32] code, [31:0] data; held until next response
o_wb_cyc  out  1  bus cycle
o_wb_stb  out  1  request strobe
o_wb_we  out  1  write enable
o_wb_addr  out  AW  word address
o_wb_data  out  32  write data
o_wb_sel  out  4  byte select, constant 4'hF
i_wb_stall  in  1  slave stall
i_wb_ack  in  1  slave acknowledge
i_wb_err  in  1  slave error
i_wb_data  in  32  read data

Behaviour:
- Opcodes:
  - 00 SETADDR: addr <= payload[AW-1:0].
  - 01 WRITE: write payload to addr.
  - 10 READ: read from addr.
  - 11 SETINC: inc <= payload[0].
- Response codes:
  - 00 WRACK: data = address written, zero-extended.
  - 01 RDDATA: data = i_wb_data.
  - 10 BUSERR: data = faulting address; used for both err and timeout.
  - 11 CFGACK: data = {inc, addr zero-extended to 31 bits}.
- States: IDLE, REQ, WAIT, RSP.
  - IDLE + i_stb, opcode 00/11: update register, go to RSP.
  - IDLE + i_stb, opcode 01/10: latch we/data, assert cyc+stb, go to REQ.
  - REQ: hold stb, addr, data and we stable. When !i_wb_stall, stb drops next edge, go to WAIT; cyc stays high.
  - WAIT: on i_wb_err, BUSERR. Else on i_wb_ack, WRACK or RDDATA with i_wb_data captured at the ack edge. In both cases cyc drops next edge, go to RSP.
  - RSP: o_rsp_stb high exactly one cycle, then IDLE.
- ack and err in the same cycle: err wins.
- ack/err while in REQ or IDLE: ignored.
- Timeout:
  - Counter clears on REQ entry and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT: drop cyc and stb, BUSERR, go to RSP.
  - A later stray ack is ignored.
- Auto-increment: after a successful WRACK or RDDATA with inc=1, addr <= addr+1, wrapping 2^AW-1 -> 0. No increment on BUSERR.
- Latency:
  - i_stb at edge N: cyc/stb high after N+1; for SETADDR/SETINC, o_rsp_stb high after N+1.
  - Accepted ack at edge M: o_rsp_stb high after M+1.
- Overrun: i_stb while o_busy=1 pulses o_cmd_drop next cycle; state and registers are unaffected.
- i_stb in the same cycle as RSP counts as busy and is dropped.
- Reset, including mid-transaction:
  - State IDLE, cyc=stb=we=0.
  - addr=0, inc=0, counter=0.
  - o_rsp_stb=0, o_rsp_word=0, o_cmd_drop=0, o_wb_data=0.
  - No response is issued for the aborted command.

Decomposition:
- Shared package uart_wb_pkg holds:
  - CMD_W=34 and the opcode and response-code enums.
  - Field position constants.
  - The state enum.
  - Also imported by the decoder and the TX response encoder.
- No sub-module. The timeout counter is inline; splitting it out adds no value.

Test Plan:
- SETADDR 0x10, SETINC 1 -> CFGACK data 0x0000_0010, then CFGACK data 0x8000_0010, each one cycle after i_stb.
- WRITE 0xDEADBEEF with stall held 3 cycles, ack 2 cycles after accept -> stb high 4 cycles, addr 0x10 stable, WRACK data 0x10; addr becomes 0x11.
- READ at 0x11, slave returns 0x12345678 with ack -> RDDATA 0x12345678; addr becomes 0x12.
- READ, slave asserts err and ack together -> BUSERR data 0x12; addr stays 0x12.
- TIMEOUT=8, WRITE with no ack -> cyc drops after 8 cycles, BUSERR; ack injected later is ignored; the next command works.
- Edge cases, each with its own check:
  - i_stb during WAIT -> o_cmd_drop pulse and no bus effect.
  - SETADDR 2^AW-1 with inc=1, then WRITE -> addr wraps to 0.
  - Reset in REQ -> cyc=0 next cycle and no response.
